// File: rtl/batrider_snd_rom_arb.sv
// Batrider sound ROM read arbiter: shares one SDRAM read slot between the
// Z80 program ROM and the two OKI PCM ports, with a one-byte hit cache per
// requester so repeated reads of the same address need no downstream fetch.
module batrider_snd_rom_arb #(
   parameter int unsigned   AW        = 22,
   parameter logic [AW-1:0] Z80_OFFS  = 22'h000000,
   parameter logic [AW-1:0] PCM0_OFFS = 22'h040000,
   parameter logic [AW-1:0] PCM1_OFFS = 22'h140000
) (
   input  logic          CLK96,
   input  logic          RESET96,
   input  logic          Z80_CS,
   input  logic [17:0]   Z80_ADDR,
   output logic          Z80_OK,
   output logic [7:0]    Z80_DOUT,
   input  logic          PCM0_CS,
   input  logic [20:0]   PCM0_ADDR,
   output logic          PCM0_OK,
   output logic [7:0]    PCM0_DOUT,
   input  logic          PCM1_CS,
   input  logic [20:0]   PCM1_ADDR,
   output logic          PCM1_OK,
   output logic [7:0]    PCM1_DOUT,
   output logic          ROM_CS,
   output logic [AW-1:0] ROM_ADDR,
   input  logic          ROM_OK,
   input  logic [7:0]    ROM_DOUT,
   output logic          BUSY
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [1:0] GNT_Z80  = 2'd0;
   localparam logic [1:0] GNT_PCM0 = 2'd1;
   localparam logic [1:0] GNT_PCM1 = 2'd2;

   logic [1:0]    st;
   logic [1:0]    gnt;
   logic          last_pcm;      // 1: PCM1 was served last, so PCM0 is next

   logic [17:0]   z80_caddr;
   logic [20:0]   pcm0_caddr;
   logic [20:0]   pcm1_caddr;
   logic [7:0]    z80_cdata;
   logic [7:0]    pcm0_cdata;
   logic [7:0]    pcm1_cdata;
   logic          z80_cvalid;
   logic          pcm0_cvalid;
   logic          pcm1_cvalid;

   logic          z80_hit, pcm0_hit, pcm1_hit;
   logic          z80_miss, pcm0_miss, pcm1_miss;
   logic [AW-1:0] z80_raddr, pcm0_raddr, pcm1_raddr;

   // Cache hit/miss detection and downstream address generation (wraps mod 2^AW)
   always_comb begin
      z80_hit    = z80_cvalid  & (z80_caddr  == Z80_ADDR);
      pcm0_hit   = pcm0_cvalid & (pcm0_caddr == PCM0_ADDR);
      pcm1_hit   = pcm1_cvalid & (pcm1_caddr == PCM1_ADDR);
      z80_miss   = Z80_CS  & ~z80_hit;
      pcm0_miss  = PCM0_CS & ~pcm0_hit;
      pcm1_miss  = PCM1_CS & ~pcm1_hit;
      z80_raddr  = Z80_OFFS  + AW'(Z80_ADDR);
      pcm0_raddr = PCM0_OFFS + AW'(PCM0_ADDR);
      pcm1_raddr = PCM1_OFFS + AW'(PCM1_ADDR);
   end

   assign Z80_OK    = Z80_CS  & z80_hit;
   assign PCM0_OK   = PCM0_CS & pcm0_hit;
   assign PCM1_OK   = PCM1_CS & pcm1_hit;
   assign Z80_DOUT  = z80_cdata;
   assign PCM0_DOUT = pcm0_cdata;
   assign PCM1_DOUT = pcm1_cdata;
   assign BUSY      = (st != ST_IDLE);

   // Arbitration FSM: grant in IDLE, skip one stale ROM_OK cycle, fill on ROM_OK
   always_ff @(posedge CLK96) begin
      if (RESET96) begin
         st          <= ST_IDLE;
         gnt         <= GNT_Z80;
         last_pcm    <= 1'b1;
         ROM_CS      <= 1'b0;
         ROM_ADDR    <= '0;
         z80_caddr   <= '0;
         pcm0_caddr  <= '0;
         pcm1_caddr  <= '0;
         z80_cdata   <= '0;
         pcm0_cdata  <= '0;
         pcm1_cdata  <= '0;
         z80_cvalid  <= 1'b0;
         pcm0_cvalid <= 1'b0;
         pcm1_cvalid <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (z80_miss) begin
                  gnt        <= GNT_Z80;
                  z80_caddr  <= Z80_ADDR;
                  z80_cvalid <= 1'b0;
                  ROM_ADDR   <= z80_raddr;
                  ROM_CS     <= 1'b1;
                  st         <= ST_GUARD;
               end else if (pcm0_miss && (!pcm1_miss || last_pcm)) begin
                  gnt         <= GNT_PCM0;
                  pcm0_caddr  <= PCM0_ADDR;
                  pcm0_cvalid <= 1'b0;
                  ROM_ADDR    <= pcm0_raddr;
                  ROM_CS      <= 1'b1;
                  st          <= ST_GUARD;
               end else if (pcm1_miss) begin
                  gnt         <= GNT_PCM1;
                  pcm1_caddr  <= PCM1_ADDR;
                  pcm1_cvalid <= 1'b0;
                  ROM_ADDR    <= pcm1_raddr;
                  ROM_CS      <= 1'b1;
                  st          <= ST_GUARD;
               end
            end
            ST_GUARD: begin
               st <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ROM_OK) begin
                  if (gnt == GNT_Z80) begin
                     z80_cdata  <= ROM_DOUT;
                     z80_cvalid <= 1'b1;
                  end
                  if (gnt == GNT_PCM0) begin
                     pcm0_cdata  <= ROM_DOUT;
                     pcm0_cvalid <= 1'b1;
                     last_pcm    <= 1'b0;
                  end
                  if (gnt == GNT_PCM1) begin
                     pcm1_cdata  <= ROM_DOUT;
                     pcm1_cvalid <= 1'b1;
                     last_pcm    <= 1'b1;
                  end
                  ROM_CS <= 1'b0;
                  st     <= ST_IDLE;
               end
            end
            default: begin
               ROM_CS <= 1'b0;
               st     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_batrider_snd_rom_arb.sv
// Scoreboard bench for batrider_snd_rom_arb: directed stimulus pushes the
// expected downstream addresses and cache-fill bytes; negedge monitors pop
// them on every new grant and every rising *_OK.
module tb_batrider_snd_rom_arb;

   logic        CLK96 = 1'b0;
   logic        RESET96;
   logic        Z80_CS;
   logic [17:0] Z80_ADDR;
   logic        Z80_OK;
   logic [7:0]  Z80_DOUT;
   logic        PCM0_CS, PCM1_CS;
   logic [20:0] PCM0_ADDR, PCM1_ADDR;
   logic        PCM0_OK, PCM1_OK;
   logic [7:0]  PCM0_DOUT, PCM1_DOUT;
   logic        ROM_CS;
   logic [21:0] ROM_ADDR;
   logic        ROM_OK;
   logic [7:0]  ROM_DOUT;
   logic        BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   logic [21:0] rom_q[$];
   logic [7:0]  z_q[$];
   logic [7:0]  p0_q[$];
   logic [7:0]  p1_q[$];

   logic prev_cs = 1'b0, prev_z = 1'b0, prev_p0 = 1'b0, prev_p1 = 1'b0;

   batrider_snd_rom_arb #(
      .AW        (22),
      .Z80_OFFS  (22'h000000),
      .PCM0_OFFS (22'h040000),
      .PCM1_OFFS (22'h3FFFFF)
   ) dut (
      .CLK96     (CLK96),
      .RESET96   (RESET96),
      .Z80_CS    (Z80_CS),
      .Z80_ADDR  (Z80_ADDR),
      .Z80_OK    (Z80_OK),
      .Z80_DOUT  (Z80_DOUT),
      .PCM0_CS   (PCM0_CS),
      .PCM0_ADDR (PCM0_ADDR),
      .PCM0_OK   (PCM0_OK),
      .PCM0_DOUT (PCM0_DOUT),
      .PCM1_CS   (PCM1_CS),
      .PCM1_ADDR (PCM1_ADDR),
      .PCM1_OK   (PCM1_OK),
      .PCM1_DOUT (PCM1_DOUT),
      .ROM_CS    (ROM_CS),
      .ROM_ADDR  (ROM_ADDR),
      .ROM_OK    (ROM_OK),
      .ROM_DOUT  (ROM_DOUT),
      .BUSY      (BUSY)
   );

   always #5 CLK96 = ~CLK96;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input logic [31:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h expected no event", nm, act);
   endtask

   // Grant monitor: every new ROM_CS assertion must match the next expected address
   always @(negedge CLK96) begin
      if (ROM_CS && !prev_cs) begin
         if (rom_q.size() == 0) fail_now("unexpected_grant", 32'(ROM_ADDR));
         else chk("grant_addr", 32'(ROM_ADDR), 32'(rom_q.pop_front()));
      end
      prev_cs <= ROM_CS;
   end

   // Fill monitor: every rising *_OK must deliver the next expected byte
   always @(negedge CLK96) begin
      if (Z80_OK && !prev_z) begin
         if (z_q.size() == 0) fail_now("unexpected_z80_ok", 32'(Z80_DOUT));
         else chk("z80_data", 32'(Z80_DOUT), 32'(z_q.pop_front()));
      end
      if (PCM0_OK && !prev_p0) begin
         if (p0_q.size() == 0) fail_now("unexpected_pcm0_ok", 32'(PCM0_DOUT));
         else chk("pcm0_data", 32'(PCM0_DOUT), 32'(p0_q.pop_front()));
      end
      if (PCM1_OK && !prev_p1) begin
         if (p1_q.size() == 0) fail_now("unexpected_pcm1_ok", 32'(PCM1_DOUT));
         else chk("pcm1_data", 32'(PCM1_DOUT), 32'(p1_q.pop_front()));
      end
      prev_z  <= Z80_OK;
      prev_p0 <= PCM0_OK;
      prev_p1 <= PCM1_OK;
   end

   task automatic tick();
      @(posedge CLK96);
      #1;
   endtask

   // Returns in the GUARD cycle (first cycle with ROM_CS high)
   task automatic wait_grant();
      for (int i = 0; i < 20; i++) begin
         if (ROM_CS) return;
         tick();
      end
      fail_now("grant_timeout", 32'(ROM_CS));
   endtask

   // Called in the WAIT cycle; returns in the IDLE cycle after the fill
   task automatic finish(input int lat, input logic [7:0] d);
      repeat (lat) tick();
      ROM_OK   = 1'b1;
      ROM_DOUT = d;
      tick();
      ROM_OK   = 1'b0;
   endtask

   task automatic serve(input int lat, input logic [7:0] d);
      wait_grant();
      tick();
      finish(lat, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET96 = 1'b1;
      Z80_CS = 1'b0; Z80_ADDR = '0;
      PCM0_CS = 1'b0; PCM0_ADDR = '0;
      PCM1_CS = 1'b0; PCM1_ADDR = '0;
      ROM_OK = 1'b0; ROM_DOUT = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_rom_cs", 32'(ROM_CS), 32'h0);
      chk("rst_rom_addr", 32'(ROM_ADDR), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_oks", 32'({Z80_OK, PCM0_OK, PCM1_OK}), 32'h0);
      chk("rst_douts", 32'({Z80_DOUT, PCM0_DOUT, PCM1_DOUT}), 32'h0);
      RESET96 = 1'b0;
      tick();

      // Z80 miss with ROM_OK already high: GUARD must ignore it
      rom_q.push_back(22'h000100);
      z_q.push_back(8'hA5);
      Z80_CS = 1'b1; Z80_ADDR = 18'h00100; ROM_OK = 1'b1; ROM_DOUT = 8'hA5;
      chk("c0_rom_cs", 32'(ROM_CS), 32'h0);
      tick();
      chk("c1_rom_cs", 32'(ROM_CS), 32'h1);
      chk("c1_rom_addr", 32'(ROM_ADDR), 32'h000100);
      chk("c1_busy", 32'(BUSY), 32'h1);
      chk("c1_z80_ok", 32'(Z80_OK), 32'h0);
      tick();
      chk("c2_z80_ok", 32'(Z80_OK), 32'h0);
      tick();
      ROM_OK = 1'b0;
      chk("c3_z80_ok", 32'(Z80_OK), 32'h1);
      chk("c3_z80_dout", 32'(Z80_DOUT), 32'hA5);
      chk("c3_rom_cs", 32'(ROM_CS), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_hit_ok", 32'(Z80_OK), 32'h1);
         chk("hold_no_fetch", 32'(ROM_CS), 32'h0);
      end
      Z80_CS = 1'b0;
      tick();

      // PCM1 address wrap: 3FFFFF + 1FFFFF = 1FFFFE mod 2^22
      rom_q.push_back(22'h1FFFFE);
      p1_q.push_back(8'h3C);
      PCM1_CS = 1'b1; PCM1_ADDR = 21'h1FFFFF;
      wait_grant();
      chk("wrap_addr", 32'(ROM_ADDR), 32'h1FFFFE);
      tick();
      finish(2, 8'h3C);
      chk("wrap_ok", 32'(PCM1_OK), 32'h1);
      tick();
      PCM1_CS = 1'b0;
      tick();

      // PCM round-robin: both keep missing, grants alternate PCM0/PCM1
      rom_q.push_back(22'h040100);
      rom_q.push_back(22'h000200);
      rom_q.push_back(22'h040102);
      rom_q.push_back(22'h000202);
      PCM0_CS = 1'b1; PCM0_ADDR = 21'h100;
      PCM1_CS = 1'b1; PCM1_ADDR = 21'h200;
      for (int i = 0; i < 4; i++) begin
         wait_grant();
         if (i < 3) begin
            PCM0_ADDR = 21'(257 + i);
            PCM1_ADDR = 21'(513 + i);
         end else begin
            PCM0_CS = 1'b0;
            PCM1_CS = 1'b0;
         end
         tick();
         finish(1, 8'h70 + 8'(i));
      end
      tick();

      // Z80 raised during a PCM1 fetch beats a pending PCM0
      rom_q.push_back(22'h0002FF);
      rom_q.push_back(22'h000200);
      rom_q.push_back(22'h040050);
      p1_q.push_back(8'h11);
      z_q.push_back(8'h22);
      p0_q.push_back(8'h33);
      PCM1_CS = 1'b1; PCM1_ADDR = 21'h300;
      wait_grant();
      Z80_CS = 1'b1; Z80_ADDR = 18'h200;
      PCM0_CS = 1'b1; PCM0_ADDR = 21'h50;
      tick();
      finish(0, 8'h11);
      chk("p1_ok", 32'(PCM1_OK), 32'h1);
      chk("gap_rom_cs", 32'(ROM_CS), 32'h0);
      chk("gap_busy", 32'(BUSY), 32'h0);
      tick();
      chk("b2b_rom_cs", 32'(ROM_CS), 32'h1);
      chk("z80_priority", 32'(ROM_ADDR), 32'h000200);
      tick();
      finish(1, 8'h22);
      chk("z80_ok", 32'(Z80_OK), 32'h1);
      tick();
      chk("pcm0_next", 32'(ROM_ADDR), 32'h040050);
      tick();
      finish(0, 8'h33);
      chk("pcm0_ok", 32'(PCM0_OK), 32'h1);
      tick();
      Z80_CS = 1'b0; PCM0_CS = 1'b0; PCM1_CS = 1'b0;
      tick();

      // PCM0 address moves 10 -> 11 during WAIT
      rom_q.push_back(22'h040010);
      rom_q.push_back(22'h040011);
      p0_q.push_back(8'h55);
      PCM0_CS = 1'b1; PCM0_ADDR = 21'h10;
      wait_grant();
      tick();
      PCM0_ADDR = 21'h11;
      finish(1, 8'h44);
      chk("stale_ok", 32'(PCM0_OK), 32'h0);
      chk("stale_fill", 32'(PCM0_DOUT), 32'h44);
      chk("refetch_gap", 32'(ROM_CS), 32'h0);
      tick();
      chk("refetch_cs", 32'(ROM_CS), 32'h1);
      chk("refetch_addr", 32'(ROM_ADDR), 32'h040011);
      tick();
      finish(0, 8'h55);
      chk("refetch_ok", 32'(PCM0_OK), 32'h1);
      tick();
      PCM0_CS = 1'b0;
      tick();

      // Reset during WAIT with a concurrent ROM_OK
      rom_q.push_back(22'h0003FF);
      PCM1_CS = 1'b1; PCM1_ADDR = 21'h400;
      wait_grant();
      tick();
      RESET96 = 1'b1; PCM1_CS = 1'b0; ROM_OK = 1'b1; ROM_DOUT = 8'h99;
      tick();
      RESET96 = 1'b0;
      chk("mrst_rom_cs", 32'(ROM_CS), 32'h0);
      chk("mrst_busy", 32'(BUSY), 32'h0);
      chk("mrst_oks", 32'({Z80_OK, PCM0_OK, PCM1_OK}), 32'h0);
      chk("mrst_douts", 32'({Z80_DOUT, PCM0_DOUT, PCM1_DOUT}), 32'h0);
      tick();
      ROM_OK = 1'b0;

      // After reset: no late fill, and PCM0 wins the first PCM tie
      rom_q.push_back(22'h040020);
      rom_q.push_back(22'h0003FF);
      p0_q.push_back(8'h77);
      p1_q.push_back(8'h66);
      PCM0_CS = 1'b1; PCM0_ADDR = 21'h20;
      PCM1_CS = 1'b1; PCM1_ADDR = 21'h400;
      chk("no_late_fill", 32'(PCM1_OK), 32'h0);
      serve(1, 8'h77);
      chk("post_rst_p0_ok", 32'(PCM0_OK), 32'h1);
      serve(2, 8'h66);
      chk("post_rst_p1_ok", 32'(PCM1_OK), 32'h1);
      tick();
      PCM0_CS = 1'b0; PCM1_CS = 1'b0;
      repeat (3) tick();

      chk("rom_q_empty", 32'(rom_q.size()), 32'h0);
      chk("fill_q_empty", 32'(z_q.size() + p0_q.size() + p1_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
